// File: rtl/power_monitor_responder.sv
// Power-rail monitor: polls a 12-bit SPI ADC round-robin over rails 0..3 and answers under/over checks by sel.
// data is registered, one clk after a sel or reading change; no backpressure, the ADC frame loop free-runs.
module power_monitor_responder #(
  parameter int          CLK_DIV = 25,
  parameter logic [11:0] LO0     = 12'd2458,
  parameter logic [11:0] LO1     = 12'd2458,
  parameter logic [11:0] LO2     = 12'd2458,
  parameter logic [11:0] LO3     = 12'd2458,
  parameter logic [11:0] HI0     = 12'd3686,
  parameter logic [11:0] HI1     = 12'd3686,
  parameter logic [11:0] HI2     = 12'd3686
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel,
  output logic       data,
  output logic [3:0] valid,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  input  logic       adc_miso
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] DIV_HOLD = 8'(CLK_DIV);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  rst_sync;
  logic        run;
  logic [7:0]  cnt;
  logic [3:0]  bit_idx;
  logic        phase_hi;
  logic        tick;
  logic        commit;
  logic [11:0] shreg;
  logic [1:0]  cur_addr;
  logic [1:0]  prev_addr;
  logic        first_frame;
  logic [11:0] reading [4];
  logic [2:0]  add3;
  logic [1:0]  rail;
  logic [11:0] lo_thr;
  logic [11:0] hi_thr;
  logic        data_nxt;

  // Reset assertion is immediate; release reaches the FSM two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run    = rst_sync[1];
  assign tick   = (cnt == DIV_LAST);
  assign commit = (state == HOLD) && (cnt == 8'd0);
  assign add3   = {1'b0, cur_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && phase_hi && (bit_idx == 4'd15)) state_nxt = HOLD;
      HOLD:    if (cnt == DIV_HOLD) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adc_cs_n = 1'b1;
    adc_sclk = 1'b1;
    adc_mosi = 1'b0;
    case (state)
      SETUP: adc_cs_n = 1'b0;
      SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = phase_hi;
        // Address occupies SCLK periods 3..5; bit_idx moves only as sclk falls.
        case (bit_idx)
          4'd2:    adc_mosi = add3[2];
          4'd3:    adc_mosi = add3[1];
          4'd4:    adc_mosi = add3[0];
          default: adc_mosi = 1'b0;
        endcase
      end
      default: begin
        adc_cs_n = 1'b1;
        adc_sclk = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      bit_idx  <= 4'd0;
      phase_hi <= 1'b0;
      shreg    <= 12'd0;
    end else begin
      case (state)
        SETUP: begin
          cnt      <= tick ? 8'd0 : cnt + 8'd1;
          bit_idx  <= 4'd0;
          phase_hi <= 1'b0;
        end
        SHIFT: begin
          if (tick) begin
            cnt      <= 8'd0;
            phase_hi <= ~phase_hi;
            if (phase_hi) begin
              bit_idx <= bit_idx + 4'd1;
            end else begin
              // Sample on the clk that raises sclk; the last 12 bits left are the result.
              shreg <= {shreg[10:0], adc_miso};
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD:    cnt <= (cnt == DIV_HOLD) ? 8'd0 : cnt + 8'd1;
        default: cnt <= 8'd0;
      endcase
    end
  end

  // A frame returns the conversion addressed by the previous frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr    <= 2'd0;
      prev_addr   <= 2'd0;
      first_frame <= 1'b1;
      valid       <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        reading[i] <= 12'd0;
      end
    end else if (commit) begin
      if (!first_frame) begin
        reading[prev_addr] <= shreg;
        valid[prev_addr]   <= 1'b1;
      end
      prev_addr   <= cur_addr;
      cur_addr    <= cur_addr + 2'd1;
      first_frame <= 1'b0;
    end
  end

  assign rail = sel[2:1];

  always_comb begin
    lo_thr = LO0;
    hi_thr = HI0;
    case (rail)
      2'd0:    begin lo_thr = LO0; hi_thr = HI0; end
      2'd1:    begin lo_thr = LO1; hi_thr = HI1; end
      2'd2:    begin lo_thr = LO2; hi_thr = HI2; end
      default: begin lo_thr = LO3; hi_thr = HI0; end
    endcase
  end

  // Without a reading yet every check reports pass.
  always_comb begin
    data_nxt = 1'b0;
    if (sel == 3'd7) begin
      data_nxt = 1'b0;
    end else if (!sel[0]) begin
      data_nxt = !valid[rail] || (reading[rail] >= lo_thr);
    end else begin
      data_nxt = valid[rail] && (reading[rail] > hi_thr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 1'b0;
    end else begin
      data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_power_monitor_responder.sv
// Directed bench for power_monitor_responder with a behavioural SPI ADC model, CLK_DIV=2.
module tb_power_monitor_responder;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       data;
  logic [3:0] valid;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_mosi;
  logic       adc_miso = 1'b1;

  always #5 clk = ~clk;

  power_monitor_responder #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .data     (data),
    .valid    (valid),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_mosi (adc_mosi),
    .adc_miso (adc_miso)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: data out on sclk fall, address in on sclk rise, converts the channel of the previous frame.
  logic [11:0] adc_val [4];
  logic [1:0]  chan_prev = 2'd0;
  logic [2:0]  addr_cap = 3'd0;
  int          period = 0;
  int          rises = 0;
  int          low_cnt = 0;
  int          cyc = 0;
  int          frames_done = 0;
  logic [2:0]  frame_addr [64];
  int          frame_rises [64];
  int          frame_low [64];
  int          fall_cyc [64];

  always @(posedge clk) cyc++;

  always @(negedge clk) if (adc_cs_n === 1'b0) low_cnt++;

  always @(negedge adc_cs_n) begin
    period   = 0;
    rises    = 0;
    low_cnt  = 0;
    addr_cap = 3'd0;
    if (frames_done < 64) fall_cyc[frames_done] = cyc;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      period++;
      if (period >= 5 && period <= 16) adc_miso = adc_val[chan_prev][16 - period];
      else adc_miso = 1'b1;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && rst_n) begin
      rises++;
      if (period >= 3 && period <= 5) addr_cap = {addr_cap[1:0], adc_mosi};
    end
  end

  always @(posedge adc_cs_n) begin
    if (rst_n && frames_done < 64) begin
      frame_addr[frames_done]  = addr_cap;
      frame_rises[frames_done] = rises;
      frame_low[frames_done]   = low_cnt;
      chan_prev                = addr_cap[1:0];
      frames_done++;
    end
  end

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_done < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < n) check("wait_frames", frames_done, n);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sel_check(input string tag, input logic [2:0] s, input logic exp);
    sel = s;
    @(posedge clk);
    @(negedge clk);
    check(tag, data, exp);
  endtask

  logic [7:0] exp_pre = 8'b0101_0101;
  int base;
  int t;

  initial begin
    adc_val[0] = 12'hA00;
    adc_val[1] = 12'h100;
    adc_val[2] = 12'hE67;
    adc_val[3] = 12'h999;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", adc_cs_n, 1'b1);
    check("rst_sclk", adc_sclk, 1'b1);
    check("rst_mosi", adc_mosi, 1'b0);
    check("rst_data", data, 1'b0);
    check("rst_valid", valid, 4'b0000);
    rst_n = 1'b1;

    for (int s = 0; s < 8; s++) begin
      sel_check($sformatf("prevalid_sel%0d", s), 3'(s), exp_pre[s]);
    end

    wait_frames(1); settle();
    check("valid_after_f0", valid, 4'b0000);
    wait_frames(2); settle();
    check("valid_after_f1", valid, 4'b0001);
    sel_check("f1_sel0_A00", 3'd0, 1'b1);
    wait_frames(3); settle();
    check("valid_after_f2", valid, 4'b0011);
    sel_check("f2_sel2_100", 3'd2, 1'b0);
    adc_val[0] = 12'd2458;
    wait_frames(4); settle();
    check("valid_after_f3", valid, 4'b0111);
    sel_check("rail2_over", 3'd5, 1'b1);
    sel_check("rail2_under", 3'd4, 1'b1);
    wait_frames(5); settle();
    check("valid_after_f4", valid, 4'b1111);
    sel_check("rail3_under", 3'd6, 1'b0);
    sel_check("sel7_all_valid", 3'd7, 1'b0);
    sel_check("rail1_over", 3'd3, 1'b0);

    wait_frames(6); settle();
    sel_check("lo0_equal", 3'd0, 1'b1);
    adc_val[0] = 12'd2457;
    wait_frames(10); settle();
    sel_check("lo0_minus1", 3'd0, 1'b0);
    adc_val[0] = 12'd3686;
    wait_frames(14); settle();
    sel_check("hi0_equal", 3'd1, 1'b0);
    sel_check("hi0_equal_under", 3'd0, 1'b1);
    sel = 3'd1;
    #1 check("sel_latency_hold", data, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("sel_latency_1clk", data, 1'b0);
    sel = 3'd0;
    adc_val[0] = 12'd3687;

    // Frame 17 stores rail 0; flip sel in the clk the reading register changes.
    wait_frames(17);
    wait_frames(18);
    @(posedge clk);
    #1 sel = 3'd1;
    @(negedge clk);
    check("simul_before", data, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("simul_hi0_plus1", data, 1'b1);

    check("f1_low_clks", frame_low[1], 33 * DIV);
    check("f1_sclk_rises", frame_rises[1], 16);
    check("f1_period", fall_cyc[2] - fall_cyc[1], 2 + 34 * DIV);
    check("f3_sclk_rises", frame_rises[3], 16);
    check("f3_period", fall_cyc[4] - fall_cyc[3], 2 + 34 * DIV);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mosi_addr_f%0d", k), frame_addr[k], 3'(k % 4));
    end

    sel = 3'd0;
    t = 0;
    while (!(adc_cs_n === 1'b0 && period == 8) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("reach_period8", period, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", adc_cs_n, 1'b1);
    check("midrst_sclk", adc_sclk, 1'b1);
    check("midrst_valid", valid, 4'b0000);
    check("midrst_data", data, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = frames_done;
    wait_frames(base + 1); settle();
    check("postrst_f0_addr", frame_addr[base], 3'd0);
    check("postrst_f0_valid", valid, 4'b0000);
    wait_frames(base + 2); settle();
    check("postrst_f1_addr", frame_addr[base + 1], 3'd1);
    check("postrst_f1_valid", valid, 4'b0001);
    sel_check("postrst_sel0", 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
